// File: rtl/multi_mode_shifter_if.sv
`default_nettype none
// ============================================================================
// Module  : multi_mode_shifter_if
// Purpose : Control/data bundle for multi_mode_shifter. Carries the abort
//           line only when MULTI_MODE_SHIFTER_ABORT_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
interface multi_mode_shifter_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int MAX_STEP    = 4,
  parameter int COUNT_WIDTH = 5
);
  localparam int STEP_WIDTH = $clog2(MAX_STEP + 1);

  logic                   start;
  logic [1:0]             mode;
  logic [STEP_WIDTH-1:0]  step_amt;
  logic [COUNT_WIDTH-1:0] shift_count;
  logic [DATA_WIDTH-1:0]  data_in;
  logic                   serial_in;
  logic                   enable;
  logic [DATA_WIDTH-1:0]  data_out;
  logic                   carry_out;
  logic                   busy;
  logic                   done;

`ifdef MULTI_MODE_SHIFTER_ABORT_EN
  logic                   abort;

  modport master (
    output start, mode, step_amt, shift_count, data_in, serial_in, enable, abort,
    input  data_out, carry_out, busy, done
  );
  modport slave (
    input  start, mode, step_amt, shift_count, data_in, serial_in, enable, abort,
    output data_out, carry_out, busy, done
  );
`else
  modport master (
    output start, mode, step_amt, shift_count, data_in, serial_in, enable,
    input  data_out, carry_out, busy, done
  );
  modport slave (
    input  start, mode, step_amt, shift_count, data_in, serial_in, enable,
    output data_out, carry_out, busy, done
  );
`endif

endinterface
`default_nettype wire

// File: rtl/multi_mode_shifter.sv
`default_nettype none
// ============================================================================
// Module  : multi_mode_shifter
// Purpose : Counted multi-mode operand shifter (LSL/LSR/ASR/ROL) with a
//           start/busy/done handshake. Optional abort: MULTI_MODE_SHIFTER_ABORT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module multi_mode_shifter #(
  parameter int DATA_WIDTH  = 16,
  parameter int MAX_STEP    = 4,
  parameter int COUNT_WIDTH = 5
) (
  input  logic                clk,
  input  logic                reset,
  multi_mode_shifter_if.slave bus
);

  localparam int c_step_w = $clog2(MAX_STEP + 1);
  localparam int c_amt_w  = $clog2(DATA_WIDTH) + 1;

  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_shift = 2'd1;
  localparam logic [1:0] c_done  = 2'd2;

  localparam logic [1:0] c_mode_lsl = 2'd0;
  localparam logic [1:0] c_mode_lsr = 2'd1;
  localparam logic [1:0] c_mode_asr = 2'd2;

  localparam logic [c_step_w-1:0]    c_step_one  = c_step_w'(1);
  localparam logic [c_step_w-1:0]    c_step_max  = c_step_w'(MAX_STEP);
  localparam logic [c_amt_w-1:0]     c_width_amt = c_amt_w'(DATA_WIDTH);
  localparam logic [COUNT_WIDTH-1:0] c_cnt_one   = COUNT_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0]  c_ones      = '1;

  logic [1:0]             state_q, state_d;
  logic [DATA_WIDTH-1:0]  data_q,  data_d;
  logic                   carry_q, carry_d;
  logic [COUNT_WIDTH-1:0] cnt_q,   cnt_d;
  logic [1:0]             mode_q,  mode_d;
  logic [c_step_w-1:0]    step_q,  step_d;

  logic                   w_abort;
  logic [c_step_w-1:0]    w_step_eff;
  logic [DATA_WIDTH-1:0]  w_fill_lo;
  logic [DATA_WIDTH-1:0]  w_fill_hi;
  logic [c_amt_w-1:0]     w_rot_amt;
  logic [DATA_WIDTH-1:0]  w_pre_left;
  logic [DATA_WIDTH-1:0]  w_pre_right;
  logic [DATA_WIDTH-1:0]  w_shifted;
  logic                   w_carry;

`ifdef MULTI_MODE_SHIFTER_ABORT_EN
  assign w_abort = bus.abort;
`else
  assign w_abort = 1'b0;
`endif

  // Zero step means one bit; oversize steps saturate at MAX_STEP.
  assign w_step_eff = (bus.step_amt == '0)        ? c_step_one :
                      (bus.step_amt > c_step_max) ? c_step_max : bus.step_amt;

  assign w_fill_lo   = bus.serial_in ? ~(c_ones << step_q) : '0;
  assign w_fill_hi   = bus.serial_in ? ~(c_ones >> step_q) : '0;
  assign w_rot_amt   = c_width_amt - {{(c_amt_w - c_step_w){1'b0}}, step_q};
  // The boundary bit is the one that lands just outside after the shift.
  assign w_pre_left  = data_q << (step_q - c_step_one);
  assign w_pre_right = data_q >> (step_q - c_step_one);

  always_comb begin
    w_shifted = data_q;
    w_carry   = 1'b0;
    case (mode_q)
      c_mode_lsl: begin
        w_shifted = (data_q << step_q) | w_fill_lo;
        w_carry   = w_pre_left[DATA_WIDTH-1];
      end
      c_mode_lsr: begin
        w_shifted = (data_q >> step_q) | w_fill_hi;
        w_carry   = w_pre_right[0];
      end
      c_mode_asr: begin
        w_shifted = $unsigned($signed(data_q) >>> step_q);
        w_carry   = w_pre_right[0];
      end
      default: begin
        w_shifted = (data_q << step_q) | (data_q >> w_rot_amt);
        w_carry   = w_pre_left[DATA_WIDTH-1];
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= c_idle;
      data_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      mode_q  <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      step_q  <= step_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    step_d  = step_q;
    case (state_q)
      c_idle: begin
        if (bus.start) begin
          data_d  = bus.data_in;
          carry_d = 1'b0;
          cnt_d   = bus.shift_count;
          mode_d  = bus.mode;
          step_d  = w_step_eff;
          state_d = (bus.shift_count == '0) ? c_done : c_shift;
        end
      end
      c_shift: begin
        if (w_abort) begin
          state_d = c_idle;
        end else if (bus.enable && (cnt_q != '0)) begin
          data_d  = w_shifted;
          carry_d = w_carry;
          cnt_d   = cnt_q - c_cnt_one;
          if (cnt_q == c_cnt_one) begin
            state_d = c_done;
          end
        end
      end
      c_done:  state_d = c_idle;
      default: state_d = c_idle;
    endcase
  end

  always_comb begin
    bus.data_out  = data_q;
    bus.carry_out = carry_q;
    bus.busy      = (state_q == c_shift) || (state_q == c_done);
    bus.done      = (state_q == c_done);
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_mode_shifter.sv
`default_nettype none
// Self-checking bench for multi_mode_shifter: directed vector table, handshake
// corner sequences and randomized operations against a bit-level reference.
module tb_multi_mode_shifter;

  localparam int DW = 16;
  localparam int MS = 4;
  localparam int CW = 5;
  localparam int SW = $clog2(MS + 1);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multi_mode_shifter_if #(.DATA_WIDTH(DW), .MAX_STEP(MS), .COUNT_WIDTH(CW)) bus_if ();

  multi_mode_shifter #(.DATA_WIDTH(DW), .MAX_STEP(MS), .COUNT_WIDTH(CW)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus_if)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [DW-1:0] din;
    logic [1:0]    mode;
    logic [SW-1:0] step;
    logic [CW-1:0] cnt;
    logic          ser;
    logic [DW-1:0] exp_data;
    logic          exp_carry;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: each output bit picked from its source position in the operand.
  function automatic logic [DW:0] ref_shift(input logic [DW-1:0] d, input logic [1:0] m,
                                            input int s, input logic ser);
    logic [DW-1:0] r;
    logic          c;
    for (int i = 0; i < DW; i++) begin
      case (m)
        2'd0:    r[i] = (i >= s)     ? d[i-s] : ser;
        2'd1:    r[i] = (i + s < DW) ? d[i+s] : ser;
        2'd2:    r[i] = (i + s < DW) ? d[i+s] : d[DW-1];
        default: r[i] = d[(i - s + DW) % DW];
      endcase
    end
    c = (m == 2'd0 || m == 2'd3) ? d[DW-s] : d[s-1];
    return {c, r};
  endfunction

  function automatic int eff_step(input int a);
    return (a == 0) ? 1 : ((a > MS) ? MS : a);
  endfunction

  task automatic drive(input logic [DW-1:0] din, input logic [1:0] m, input logic [SW-1:0] st,
                       input logic [CW-1:0] cnt, input logic ser);
    bus_if.data_in     = din;
    bus_if.mode        = m;
    bus_if.step_amt    = st;
    bus_if.shift_count = cnt;
    bus_if.serial_in   = ser;
  endtask

  task automatic run_op(input string tag, input vec_t v);
    int   cyc;
    logic busy_ok;
    @(negedge clk);
    drive(v.din, v.mode, v.step, v.cnt, v.ser);
    bus_if.enable = 1'b1;
    bus_if.start  = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    cyc     = 1;
    busy_ok = 1'b1;
    while (bus_if.done !== 1'b1 && cyc < 100) begin
      if (bus_if.busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, cyc, 32'(v.cnt) + 1);
    check({tag, "_busy"}, {31'd0, busy_ok & bus_if.busy}, 32'd1);
    check({tag, "_data"}, 32'(bus_if.data_out), 32'(v.exp_data));
    check({tag, "_carry"}, 32'(bus_if.carry_out), 32'(v.exp_carry));
    @(negedge clk);
    check({tag, "_idle"}, {30'd0, bus_if.busy, bus_if.done}, 32'd0);
    check({tag, "_hold"}, 32'(bus_if.data_out), 32'(v.exp_data));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen_done;
    int   cyc;

    bus_if.start  = 1'b0;
    bus_if.enable = 1'b0;
`ifdef MULTI_MODE_SHIFTER_ABORT_EN
    bus_if.abort  = 1'b0;
`endif
    drive('0, 2'd0, '0, '0, 1'b0);

    vecs[0] = '{16'h0003, 2'd0, 3'd1, 5'd3, 1'b0, 16'h0018, 1'b0};
    vecs[1] = '{16'h8010, 2'd2, 3'd4, 5'd2, 1'b0, 16'hFF80, 1'b0};
    vecs[2] = '{16'h4001, 2'd3, 3'd2, 5'd1, 1'b0, 16'h0005, 1'b1};
    vecs[3] = '{16'h1234, 2'd0, 3'd1, 5'd0, 1'b0, 16'h1234, 1'b0};
    vecs[4] = '{16'h0001, 2'd0, 3'd7, 5'd1, 1'b0, 16'h0010, 1'b0};
    vecs[5] = '{16'h0000, 2'd1, 3'd3, 5'd1, 1'b1, 16'hE000, 1'b0};
    vecs[6] = '{16'hABCD, 2'd3, 3'd4, 5'd4, 1'b0, 16'hABCD, 1'b1};
    vecs[7] = '{16'h1234, 2'd0, 3'd4, 5'd2, 1'b1, 16'h34FF, 1'b0};
    vecs[8] = '{16'h8001, 2'd1, 3'd0, 5'd1, 1'b0, 16'h4000, 1'b1};

    repeat (2) @(negedge clk);
    check("reset_state", {13'd0, bus_if.data_out, bus_if.carry_out, bus_if.busy, bus_if.done}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) run_op($sformatf("vec%0d", i), vecs[i]);

    // start pulsed while busy must not restart or alter the operation
    @(negedge clk);
    drive(16'h4001, 2'd3, 3'd2, 5'd1, 1'b0);
    bus_if.enable = 1'b1;
    bus_if.start  = 1'b1;
    @(negedge clk);
    drive(16'hFFFF, 2'd0, 3'd1, 5'd5, 1'b1);
    @(negedge clk);
    bus_if.start = 1'b0;
    check("busy_start_done", {31'd0, bus_if.done}, 32'd1);
    check("busy_start_data", 32'(bus_if.data_out), 32'h0005);
    repeat (2) begin
      @(negedge clk);
      check("busy_start_idle", {15'd0, bus_if.busy, bus_if.data_out}, 32'h0005);
    end

    // stall: enable low for three edges after the first shift
    @(negedge clk);
    drive(16'h00F0, 2'd1, 3'd1, 5'd2, 1'b1);
    bus_if.enable = 1'b1;
    bus_if.start  = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    @(negedge clk);
    check("stall_first", 32'(bus_if.data_out), 32'h8078);
    bus_if.enable = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stall_hold", {15'd0, bus_if.busy, bus_if.data_out}, 32'h18078);
    end
    bus_if.enable = 1'b1;
    @(negedge clk);
    check("stall_done", {31'd0, bus_if.done}, 32'd1);
    check("stall_final", {15'd0, bus_if.carry_out, bus_if.data_out}, 32'hC03C);

    // asynchronous reset in the middle of a count=5 operation
    @(negedge clk);
    drive(16'h00FF, 2'd0, 3'd1, 5'd5, 1'b0);
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("midreset_outputs", {13'd0, bus_if.data_out, bus_if.carry_out, bus_if.busy, bus_if.done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus_if.done === 1'b1 || bus_if.busy === 1'b1) seen_done = 1'b1;
    end
    check("midreset_no_done", {31'd0, seen_done}, 32'd0);
    run_op("after_reset", vecs[0]);

`ifdef MULTI_MODE_SHIFTER_ABORT_EN
    @(negedge clk);
    drive(16'h0001, 2'd0, 3'd1, 5'd5, 1'b0);
    bus_if.enable = 1'b1;
    bus_if.start  = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus_if.abort = 1'b1;
    @(negedge clk);
    bus_if.abort = 1'b0;
    check("abort_idle", {14'd0, bus_if.busy, bus_if.done, bus_if.data_out}, 32'h0004);
    seen_done = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus_if.done === 1'b1) seen_done = 1'b1;
    end
    check("abort_no_done", {31'd0, seen_done}, 32'd0);
    check("abort_hold", 32'(bus_if.data_out), 32'h0004);
`endif

    // randomized operations with random stalls against the reference model
    for (int n = 0; n < 40; n++) begin
      logic [DW-1:0] m_data;
      logic          m_carry;
      logic [DW:0]   r;
      int            rem;
      int            s;
      logic [1:0]    m;
      logic          ser;
      logic          ok;
      m      = 2'($urandom_range(3));
      ser    = 1'($urandom_range(1));
      rem    = $urandom_range(6);
      m_data = DW'($urandom);
      s      = eff_step($urandom_range(7));
      @(negedge clk);
      drive(m_data, m, SW'(s == 1 && ($urandom_range(1) == 1) ? 0 : s), CW'(rem), ser);
      if (s == MS && $urandom_range(1) == 1) bus_if.step_amt = SW'(MS + 1 + $urandom_range(2));
      bus_if.enable = 1'b1;
      bus_if.start  = 1'b1;
      m_carry = 1'b0;
      @(negedge clk);
      bus_if.start = 1'b0;
      ok  = 1'b1;
      cyc = 0;
      while (rem > 0 && cyc < 200) begin
        if (bus_if.done !== 1'b0 || bus_if.busy !== 1'b1) ok = 1'b0;
        bus_if.enable = ($urandom_range(3) != 0);
        if (bus_if.enable) begin
          r       = ref_shift(m_data, m, s, ser);
          m_data  = r[DW-1:0];
          m_carry = r[DW];
          rem--;
        end
        @(negedge clk);
        cyc++;
      end
      check($sformatf("rand%0d_flow", n), {31'd0, ok}, 32'd1);
      check($sformatf("rand%0d_done", n), {31'd0, bus_if.done}, 32'd1);
      check($sformatf("rand%0d_result", n), {15'd0, bus_if.carry_out, bus_if.data_out},
            {15'd0, m_carry, m_data});
      @(negedge clk);
      check($sformatf("rand%0d_idle", n), {30'd0, bus_if.busy, bus_if.done}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multi_mode_shifter.md
Name: multi_mode_shifter

Overview:
- Parametrised successor to the multiplier's single-direction shift register.
- Loads an operand, then runs a counted shift sequence under a start/busy/done handshake.
- Each shift moves the data by a programmable amount in one of four modes.
- Serves the sequential multiplier and divider datapaths as the operand shifter, so the control unit no longer has to count shifts itself.

Parameters:
- DATA_WIDTH, 16, width of the shifted operand (minimum 4).
- MAX_STEP, 4, largest shift amount per cycle (1 to DATA_WIDTH-1).
- COUNT_WIDTH, 5, width of the shift-count field.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request to begin an operation; sampled only in IDLE.
- mode  input  2  shift mode: 00 logical left, 01 logical right, 10 arithmetic right, 11 rotate left.
- step_amt  input  $clog2(MAX_STEP+1)  bits moved per shift.
- shift_count  input  COUNT_WIDTH  number of shifts to perform.
- data_in  input  DATA_WIDTH  operand loaded on start.
- serial_in  input  1  fill bit for logical modes.
- enable  input  1  allows a shift in SHIFT when 1; stalls when 0.
- data_out  output  DATA_WIDTH  current register contents.
- carry_out  output  1  boundary bit from the most recent shift.
- busy  output  1  high in SHIFT and DONE.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (asynchronous, active-low, any state):
  - state goes to IDLE; data_out, carry_out, busy and done go to 0; the internal counter and latched mode/step clear.
  - Reset mid-operation abandons the operation with no done pulse.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - On the edge where start=1: load data_in into the register; latch mode, effective step and shift_count; clear carry_out.
  - Go to SHIFT if shift_count≠0, else go to DONE.
- SHIFT:
  - On each edge with enable=1: apply one shift of the effective step and decrement the counter.
  - When the counter goes from 1 to 0, move to DONE.
  - enable=0: register, counter and carry_out hold.
- DONE:
  - done=1 for exactly one cycle, then return to IDLE.
- busy is combinationally high in SHIFT and DONE.
- Latency: with enable held high, done is high during cycle shift_count+1 after the start edge. For shift_count=0, done is high in the cycle right after the start edge.
- Effective step:
  - step_amt=0 is treated as 1.
  - step_amt>MAX_STEP is clamped to MAX_STEP.
  - The step is latched at start; step_amt changes during an operation are ignored.
- Shift modes, with s = effective step:
  - 00 logical left: vacated low bits filled with serial_in.
  - 01 logical right: vacated high bits filled with serial_in.
  - 10 arithmetic right: vacated high bits filled with the pre-shift MSB.
  - 11 rotate left: bits leaving the MSB re-enter at the LSB.
- carry_out:
  - Left modes: pre-shift bit DATA_WIDTH-s.
  - Right modes: pre-shift bit s-1.
- start is ignored while busy. mode, shift_count and data_in are sampled only at the start edge.
- data_out and carry_out hold their final values in IDLE until the next start or reset.
- The counter never underflows; the operation always terminates after exactly shift_count enabled shifts.

Optional Feature:
- Macro: MULTI_MODE_SHIFTER_ABORT_EN.
- Defined: adds a 1-bit input port abort.
  - abort=1 in SHIFT: return to IDLE on that edge; no done pulse; no shift that cycle; data_out and carry_out keep their partial values.
  - abort has priority over enable.
  - abort is ignored in IDLE and DONE.
- Not defined: no abort port; every started operation runs to completion unless reset.

Test Plan:
1. Logical left: data_in=0x0003, mode=00, step=1, count=3, serial_in=0, enable=1 -> busy for 4 cycles, done in the 4th cycle, data_out=0x0018, carry_out=0.
2. Arithmetic right: data_in=0x8010, mode=10, step=4, count=2 -> data_out=0xFF80, carry_out=0, single done pulse.
3. Rotate left: data_in=0x4001, mode=11, step=2, count=1 -> data_out=0x0005, carry_out=1; a start pulsed during busy is ignored.
4. Stall: mode=01, data_in=0x00F0, step=1, count=2, serial_in=1; enable low 3 cycles after the first shift -> data_out holds 0x8078 while stalled; final 0xC03C; done 3 cycles later than unstalled.
5. Boundaries:
   - count=0 with data_in=0x1234 -> done the cycle after start, data_out=0x1234.
   - step_amt=7, mode=00, count=1, data_in=0x0001 -> data_out=0x0010 (clamped to MAX_STEP=4).
6. Reset mid-operation: reset low during SHIFT of a count=5 operation -> data_out, busy, done and carry_out are 0 immediately; no done pulse; a subsequent start runs normally. With MULTI_MODE_SHIFTER_ABORT_EN defined, abort during SHIFT -> IDLE, no done, partial data_out retained.
